// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared CPU constants and fetch sequencer state encoding
package pc_sequencer_pkg;

  localparam int unsigned DEFAULT_PC_W     = 8;
  localparam logic [7:0]  DEFAULT_RESET_PC = 8'h00;

  // Fetch sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_HOLD     = 2'd2,
    ST_REDIRECT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC sequencer with req/ack fetch and branch redirect
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned     PC_W     = DEFAULT_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  input  logic            cc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            ir_valid,
  output logic [PC_W-1:0] ir_pc,
  output logic            flush
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic [PC_W-1:0] ir_pc_q, ir_pc_d;
  logic            br_taken;

  // Sequential fetch assumes not-taken; only a taken branch disturbs the flow
  assign br_taken = br_valid & cc;

  // State, PC and delivery registers; reset aborts any outstanding fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_valid_q <= 1'b0;
      ir_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_valid_q <= ir_valid_d;
      ir_pc_q    <= ir_pc_d;
    end
  end

  // Next-state and PC update; a taken branch beats a same-cycle ack
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_valid_d = 1'b0;
    ir_pc_d    = ir_pc_q;
    case (state_q)
      ST_IDLE: begin
        state_d = stall ? ST_HOLD : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (br_taken) begin
          pc_d    = br_target;
          state_d = ST_REDIRECT;
        end else if (imem_ack) begin
          pc_d       = pc_q + PC_W'(1);
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          state_d    = stall ? ST_HOLD : ST_ISSUE;
        end
        // without ack the request stays up; stall cannot withdraw it
      end
      ST_HOLD: begin
        if (br_taken) begin
          pc_d    = br_target;
          state_d = ST_REDIRECT;
        end else if (!stall) begin
          state_d = ST_ISSUE;
        end
      end
      ST_REDIRECT: begin
        state_d = stall ? ST_HOLD : ST_ISSUE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded only from registers, so no input reaches an output combinationally
  assign imem_req  = (state_q == ST_ISSUE);
  assign imem_addr = pc_q;
  assign flush     = (state_q == ST_REDIRECT);
  assign ir_valid  = ir_valid_q;
  assign ir_pc     = ir_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam int unsigned PC_W = 8;
  localparam logic [7:0]  RPC  = 8'h10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stall = 1'b0;
  logic            br_valid = 1'b0;
  logic [PC_W-1:0] br_target = '0;
  logic            cc = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic            ir_valid;
  logic [PC_W-1:0] ir_pc;
  logic            flush;

  int checks = 0;
  int failures = 0;

  // Behavioural model: what the fetch stage should be showing this cycle
  logic       m_idle;
  logic       m_req;
  logic       m_flush;
  logic [7:0] m_pc;
  logic       m_ir_valid;
  logic [7:0] m_ir_pc;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid),
    .br_target(br_target), .cc(cc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .ir_valid(ir_valid),
    .ir_pc(ir_pc), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_idle = 1'b1; m_req = 1'b0; m_flush = 1'b0;
    m_pc = RPC; m_ir_valid = 1'b0; m_ir_pc = 8'h00;
  endtask

  task automatic model_step(input logic s, input logic bt, input logic [7:0] t, input logic a);
    logic n_req;
    logic n_flush;
    n_flush = 1'b0;
    m_ir_valid = 1'b0;
    if (m_idle || m_flush) begin
      n_req = !s;                         // branches ignored after reset and during flush
    end else if (bt) begin
      m_pc = t; n_flush = 1'b1; n_req = 1'b0;
    end else if (m_req) begin
      if (a) begin
        m_ir_valid = 1'b1; m_ir_pc = m_pc; m_pc = m_pc + 8'd1; n_req = !s;
      end else begin
        n_req = 1'b1;                     // pending request cannot be withdrawn
      end
    end else begin
      n_req = !s;
    end
    m_req = n_req; m_flush = n_flush; m_idle = 1'b0;
  endtask

  // Drive one cycle of inputs at the falling edge, return at the next falling edge
  task automatic cycle(input logic s, input logic bv, input logic c, input logic [7:0] t, input logic a);
    stall = s; br_valid = bv; cc = c; br_target = t; imem_ack = a;
    @(posedge clk);
    model_step(s, bv & c, t, a);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 0; br_valid = 0; cc = 0; imem_ack = 0; br_target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    checks++; if (imem_addr !== RPC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RPC); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir_valid got=%0b exp=0", ir_valid); end
    checks++; if (ir_pc !== 8'h00) begin failures++; $display("FAIL reset_ir_pc got=%h exp=00", ir_pc); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", flush); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    cycle(0, 0, 0, 8'h00, 1);
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL stream_first_req got=%0b exp=1", imem_req); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid got=%0b exp=0", ir_valid); end
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 8'h00, 1);
      checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%0b exp=1", k, ir_valid); end
      checks++; if (ir_pc !== 8'(RPC + k)) begin failures++; $display("FAIL stream_ir_pc k=%0d got=%h exp=%h", k, ir_pc, 8'(RPC + k)); end
      checks++; if (imem_addr !== 8'(RPC + k + 1)) begin failures++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, imem_addr, 8'(RPC + k + 1)); end
    end
  endtask

  task automatic test_slow_memory();
    logic [7:0] p;
    p = m_pc;
    cycle(1, 0, 0, 8'h00, 0);
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL slow_req_stall got=%0b exp=1", imem_req); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL slow_valid_wait got=%0b exp=0", ir_valid); end
    cycle(0, 0, 0, 8'h00, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== p) begin failures++; $display("FAIL slow_req_hold got=%0b/%h exp=1/%h", imem_req, imem_addr, p); end
    cycle(0, 0, 0, 8'h00, 1);
    checks++; if (ir_valid !== 1'b1 || ir_pc !== p) begin failures++; $display("FAIL slow_deliver got=%0b/%h exp=1/%h", ir_valid, ir_pc, p); end
    cycle(0, 0, 0, 8'h00, 0);
    checks++; if (imem_addr !== 8'(p + 1)) begin failures++; $display("FAIL slow_single_inc got=%h exp=%h", imem_addr, 8'(p + 1)); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL slow_no_repeat got=%0b exp=0", ir_valid); end
  endtask

  task automatic test_taken_branch();
    int n;
    n = 0;
    while (m_pc != 8'h20 && n < 64) begin
      cycle(0, 0, 0, 8'h00, 1);
      n++;
    end
    checks++; if (n >= 64) begin failures++; $display("FAIL branch_reach_20 got=timeout exp=pc20"); end
    checks++; if (imem_addr !== 8'h20 || imem_req !== 1'b1) begin failures++; $display("FAIL branch_pre got=%0b/%h exp=1/20", imem_req, imem_addr); end
    cycle(0, 1, 1, 8'h80, 1);
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL branch_ack_discard got=%0b exp=0", ir_valid); end
    checks++; if (flush !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL branch_flush got=%0b/%0b exp=1/0", flush, imem_req); end
    cycle(0, 0, 0, 8'h00, 0);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL branch_flush_once got=%0b exp=0", flush); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h80) begin failures++; $display("FAIL branch_target got=%0b/%h exp=1/80", imem_req, imem_addr); end
    cycle(0, 0, 0, 8'h00, 1);
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 8'h80) begin failures++; $display("FAIL branch_ir_pc got=%0b/%h exp=1/80", ir_valid, ir_pc); end
  endtask

  task automatic test_not_taken();
    logic [7:0] p;
    p = m_pc;
    cycle(0, 1, 0, 8'h33, 1);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL nt_flush got=%0b exp=0", flush); end
    checks++; if (ir_valid !== 1'b1 || ir_pc !== p) begin failures++; $display("FAIL nt_ir got=%0b/%h exp=1/%h", ir_valid, ir_pc, p); end
    cycle(0, 0, 0, 8'h00, 1);
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 8'(p + 1)) begin failures++; $display("FAIL nt_cont got=%0b/%h exp=1/%h", ir_valid, ir_pc, 8'(p + 1)); end
  endtask

  task automatic test_stall_branch();
    cycle(1, 1, 1, 8'h40, 1);
    checks++; if (flush !== 1'b1 || ir_valid !== 1'b0) begin failures++; $display("FAIL sb_flush got=%0b/%0b exp=1/0", flush, ir_valid); end
    cycle(1, 0, 0, 8'h00, 0);
    checks++; if (imem_req !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL sb_hold got=%0b/%0b exp=0/0", imem_req, flush); end
    cycle(1, 1, 1, 8'h55, 0);
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL sb_hold_branch got=%0b exp=1", flush); end
    cycle(0, 0, 0, 8'h00, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h55) begin failures++; $display("FAIL sb_resume got=%0b/%h exp=1/55", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    cycle(0, 1, 1, 8'hFF, 0);
    cycle(0, 0, 0, 8'h00, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'hFF) begin failures++; $display("FAIL wrap_pre got=%0b/%h exp=1/ff", imem_req, imem_addr); end
    cycle(0, 0, 0, 8'h00, 1);
    checks++; if (ir_pc !== 8'hFF || imem_addr !== 8'h00) begin failures++; $display("FAIL wrap got=%h/%h exp=ff/00", ir_pc, imem_addr); end
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 0, 8'h00, 1);
    imem_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (imem_req !== 1'b0 || flush !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("FAIL areset_ctrl got=%0b%0b%0b exp=000", imem_req, flush, ir_valid); end
    checks++; if (imem_addr !== RPC || ir_pc !== 8'h00) begin failures++; $display("FAIL areset_data got=%h/%h exp=%h/00", imem_addr, ir_pc, RPC); end
    imem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL areset_late_ack got=%0b/%0b exp=0/0", ir_valid, imem_req); end
    imem_ack = 1'b0;
    rst_n = 1'b1;
    cycle(0, 0, 0, 8'h00, 1);
    checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC) begin failures++; $display("FAIL areset_restart got=%0b/%0b/%h exp=0/1/%h", ir_valid, imem_req, imem_addr, RPC); end
  endtask

  task automatic test_random();
    logic s, bv, c, a;
    logic [7:0] t;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      bv = ($urandom_range(0, 4) == 0);
      c  = 1'($urandom);
      a  = 1'($urandom);
      t  = 8'($urandom);
      cycle(s, bv, c, t, a);
      checks++; if (imem_req !== m_req) begin failures++; $display("FAIL rand_req i=%0d got=%0b exp=%0b", i, imem_req, m_req); end
      checks++; if (imem_addr !== m_pc) begin failures++; $display("FAIL rand_addr i=%0d got=%h exp=%h", i, imem_addr, m_pc); end
      checks++; if (flush !== m_flush) begin failures++; $display("FAIL rand_flush i=%0d got=%0b exp=%0b", i, flush, m_flush); end
      checks++; if (ir_valid !== m_ir_valid) begin failures++; $display("FAIL rand_valid i=%0d got=%0b exp=%0b", i, ir_valid, m_ir_valid); end
      checks++; if (ir_pc !== m_ir_pc) begin failures++; $display("FAIL rand_ir_pc i=%0d got=%h exp=%h", i, ir_pc, m_ir_pc); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_slow_memory();
    test_taken_branch();
    test_not_taken();
    test_stall_branch();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
